// File: rtl/ge_pkg.sv
// ---------------------------------------------------------------------------
// ge_pkg -- definitions shared by every game-evaluation stage.
//
// Contents:
//   SCORE_W / BONUS_W  widths of score and bonus fields
//   SCORE_MAX          ceiling applied to work samples and final scores
//   BONUS_SHIFT        bonus and luck are each weighted by 2**BONUS_SHIFT (x4)
//   ge_state_t         evaluation FSM encoding (IDLE=0, ACCUM=1, JUDGE=2, DONE=3)
//   sat_score()        clamp a score-width value to SCORE_MAX
// ---------------------------------------------------------------------------
package ge_pkg;

    localparam int SCORE_W     = 7;
    localparam int BONUS_W     = 2;
    localparam int SCORE_MAX   = 100;
    localparam int BONUS_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_JUDGE = 2'd2,
        ST_DONE  = 2'd3
    } ge_state_t;

    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] v);
        return (v > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : v;
    endfunction

endpackage

// File: rtl/ge_judge.sv
// ---------------------------------------------------------------------------
// ge_judge -- combinational verdict logic for an evaluation stage.
//
// Averages an accumulated sum of 2**LOG2_ROUNDS samples, adds the weighted
// bonus and luck, clamps to SCORE_MAX and compares against the hardness.
//
// Ports:
//   acc        in   accumulated sample sum (SCORE_W+LOG2_ROUNDS bits)
//   bonus      in   incoming bonus, 0..3
//   luck       in   luck value, 0..3
//   hard       in   hardness threshold; the score must exceed it strictly
//   pass       out  verdict
//   bonus_out  out  top two score bits on pass, zero on fail
//   score      out  clamped score, 0..SCORE_MAX
// ---------------------------------------------------------------------------
module ge_judge
    import ge_pkg::*;
#(
    parameter int LOG2_ROUNDS = 2
) (
    input  logic [SCORE_W+LOG2_ROUNDS-1:0] acc,
    input  logic [BONUS_W-1:0]             bonus,
    input  logic [BONUS_W-1:0]             luck,
    input  logic [SCORE_W-1:0]             hard,
    output logic                           pass,
    output logic [BONUS_W-1:0]             bonus_out,
    output logic [SCORE_W-1:0]             score
);

    logic [SCORE_W-1:0] avg;
    logic [SCORE_W-1:0] total;

    // Floor division by the sample count is a plain bit-slice.
    assign avg = acc[SCORE_W+LOG2_ROUNDS-1:LOG2_ROUNDS];

    // Worst case 100 + 12 + 12 = 124 still fits in SCORE_W bits.
    assign total = avg
                 + SCORE_W'({bonus, {BONUS_SHIFT{1'b0}}})
                 + SCORE_W'({luck,  {BONUS_SHIFT{1'b0}}});

    assign score     = sat_score(total);
    assign pass      = (score > hard);
    assign bonus_out = pass ? score[SCORE_W-1 -: BONUS_W] : '0;

endmodule

// File: rtl/stage3_eval.sv
// ---------------------------------------------------------------------------
// stage3_eval -- stage-3 game evaluation.
//
// After a start pulse, collects 2**LOG2_ROUNDS work samples, judges their
// average (plus bonus and luck) against the latched hardness, and presents
// pass3/bonus3/score3 with a one-cycle done pulse. A failed stage-2 verdict
// skips straight to a zero result.
//
// Optional build macro STAGE3_TIMEOUT_EN adds an idle-cycle watchdog in ACCUM
// (parameter TIMEOUT_CYC) and a timeout output flagging the abort.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin evaluation (ignored while busy)
//   pass2, bonus2       stage-2 verdict, latched at start
//   hard, luck          random hardness / luck, latched at start
//   work_vld, work      work sample strobe and value
//   busy                high outside IDLE
//   done                one-cycle result strobe
//   pass3, bonus3,
//   score3              registered result, held until next done or reset
//   timeout             (STAGE3_TIMEOUT_EN only) abort flag, valid with done
// ---------------------------------------------------------------------------
module stage3_eval
    import ge_pkg::*;
#(
    parameter int LOG2_ROUNDS = 2
`ifdef STAGE3_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pass2,
    input  logic [BONUS_W-1:0] bonus2,
    input  logic [SCORE_W-1:0] hard,
    input  logic [BONUS_W-1:0] luck,
    input  logic               work_vld,
    input  logic [SCORE_W-1:0] work,
    output logic               busy,
    output logic               done,
    output logic               pass3,
    output logic [BONUS_W-1:0] bonus3,
    output logic [SCORE_W-1:0] score3
`ifdef STAGE3_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    localparam int ACC_W = SCORE_W + LOG2_ROUNDS;
    localparam int CNT_W = LOG2_ROUNDS + 1;
    // Count value held just before the final sample is accepted.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_ROUNDS) - 1);

    ge_state_t          state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BONUS_W-1:0] bonus2_reg;
    logic [BONUS_W-1:0] luck_reg;
    logic [SCORE_W-1:0] hard_reg;
    logic               done_reg;
    logic               pass3_reg;
    logic [BONUS_W-1:0] bonus3_reg;
    logic [SCORE_W-1:0] score3_reg;

`ifdef STAGE3_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(TIMEOUT_CYC - 1);
    logic [IDLE_W-1:0]  idle_reg;
    logic               timeout_reg;
`endif

    logic [SCORE_W-1:0] work_sat;
    logic               j_pass;
    logic [BONUS_W-1:0] j_bonus;
    logic [SCORE_W-1:0] j_score;

    assign work_sat = sat_score(work);

    ge_judge #(
        .LOG2_ROUNDS(LOG2_ROUNDS)
    ) u_judge (
        .acc      (acc_reg),
        .bonus    (bonus2_reg),
        .luck     (luck_reg),
        .hard     (hard_reg),
        .pass     (j_pass),
        .bonus_out(j_bonus),
        .score    (j_score)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            bonus2_reg <= '0;
            luck_reg   <= '0;
            hard_reg   <= '0;
            done_reg   <= 1'b0;
            pass3_reg  <= 1'b0;
            bonus3_reg <= '0;
            score3_reg <= '0;
`ifdef STAGE3_TIMEOUT_EN
            idle_reg    <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            // Strobes are high only in the DONE cycle that follows their set.
            done_reg <= 1'b0;
`ifdef STAGE3_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        bonus2_reg <= bonus2;
                        luck_reg   <= luck;
                        hard_reg   <= hard;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
`ifdef STAGE3_TIMEOUT_EN
                        idle_reg   <= '0;
`endif
                        if (!pass2) begin
                            pass3_reg  <= 1'b0;
                            bonus3_reg <= '0;
                            score3_reg <= '0;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_DONE;
                        end else begin
                            state_reg  <= ST_ACCUM;
                        end
                    end
                end

                ST_ACCUM: begin
                    if (work_vld) begin
                        acc_reg <= acc_reg + ACC_W'(work_sat);
                        cnt_reg <= cnt_reg + 1'b1;
`ifdef STAGE3_TIMEOUT_EN
                        idle_reg <= '0;
`endif
                        if (cnt_reg == LAST_CNT) begin
                            state_reg <= ST_JUDGE;
                        end
                    end
`ifdef STAGE3_TIMEOUT_EN
                    else if (idle_reg == LAST_IDLE) begin
                        pass3_reg   <= 1'b0;
                        bonus3_reg  <= '0;
                        score3_reg  <= '0;
                        done_reg    <= 1'b1;
                        timeout_reg <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        idle_reg <= idle_reg + 1'b1;
                    end
`endif
                end

                ST_JUDGE: begin
                    pass3_reg  <= j_pass;
                    bonus3_reg <= j_bonus;
                    score3_reg <= j_score;
                    done_reg   <= 1'b1;
                    state_reg  <= ST_DONE;
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = done_reg;
    assign pass3  = pass3_reg;
    assign bonus3 = bonus3_reg;
    assign score3 = score3_reg;
`ifdef STAGE3_TIMEOUT_EN
    assign timeout = timeout_reg;
`endif

endmodule

// File: doc/stage3_eval.md
Name: stage3_eval

Overview:
- Game-evaluation stage directly downstream of stage 2.
- Consumes the stage-2 verdict (pass2, bonus2) and collects 2**LOG2_ROUNDS per-cycle work samples.
- Averages the samples, applies the bonus and luck adders, and judges the result against a random hardness value.
- Produces registered pass3/bonus3/score3 with a one-cycle done pulse for stage 4.

Parameters:
- LOG2_ROUNDS, 2, log2 of the number of work samples per evaluation (1..3, so 2..8 samples).
- TIMEOUT_CYC, 16, maximum idle cycles between work samples; used only when STAGE3_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse that begins an evaluation; sampled only in IDLE.
- pass2  input  1  stage-2 pass flag.
- bonus2  input  2  stage-2 bonus, 0..3.
- hard  input  7  random hardness, 0..100; latched at start.
- luck  input  2  random luck, 0..3; latched at start.
- work_vld  input  1  qualifies work in this cycle.
- work  input  7  work sample, nominally 0..100.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; results are valid in this cycle.
- pass3  output  1  stage-3 pass flag.
- bonus3  output  2  stage-3 bonus.
- score3  output  7  clamped score, 0..100.

Behaviour:
- Reset: synchronous; forces state IDLE and clears the accumulator, sample counter and all outputs (busy, done, pass3, bonus3, score3 = 0). A reset mid-evaluation aborts it and produces no done.
- FSM states: IDLE, ACCUM, JUDGE, DONE.
- IDLE:
  - On start=1: latch pass2, bonus2, hard and luck; clear the accumulator and counter.
  - If the latched pass2=0, go to DONE with a fail result.
  - Otherwise go to ACCUM.
  - work_vld is ignored in IDLE.
- ACCUM:
  - Each cycle with work_vld=1: saturate the sample (work>100 becomes 100), add it to the accumulator (7+LOG2_ROUNDS bits, cannot overflow) and increment the counter.
  - When the sample that makes count = 2**LOG2_ROUNDS is accepted, go to JUDGE.
  - Cycles with work_vld=0 only wait (no timeout without the optional feature).
- JUDGE (single cycle):
  - avg = accumulator >> LOG2_ROUNDS (floor).
  - total = avg + 4*bonus2 + 4*luck, using the latched values; 7 bits, maximum 124, no overflow.
  - score = 100 if total>100, else total.
  - Pass condition: score > latched hard (strict). Equal values fail.
  - On pass, register pass3=1, bonus3=score[6:5], score3=score.
  - On fail, register pass3=0, bonus3=0, score3=score.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Fail path from IDLE (pass2=0): pass3=0, bonus3=0, score3=0.
- Outputs pass3, bonus3 and score3 hold their values until the next done or reset.
- Latency:
  - done is high 2 cycles after the cycle in which the last work sample is accepted.
  - done is high 1 cycle after start when pass2=0.
- start asserted while busy is ignored; no queuing.
- start and work_vld in the same IDLE cycle: the sample is not counted.

Optional Feature:
- Macro: STAGE3_TIMEOUT_EN.
- Defined:
  - An idle counter in ACCUM counts consecutive cycles with work_vld=0 and resets on any accepted sample.
  - When it reaches TIMEOUT_CYC, go to DONE with pass3=0, bonus3=0, score3=0.
  - Additional output port timeout (1 bit), asserted together with done on a timeout abort and 0 otherwise.
- Not defined: no idle counter, no timeout port; ACCUM waits indefinitely.

Decomposition:
- Shared package ge_pkg, used by all stages:
  - SCORE_MAX=100 and BONUS_SHIFT=2 (the 4x bonus/luck weight).
  - The FSM state encoding (IDLE=0, ACCUM=1, JUDGE=2, DONE=3).
  - The score/bonus width constants.
- One sub-module, ge_judge: purely combinational avg/total/clamp/compare/bonus logic. It is reusable by later stages and is registered by stage3_eval in JUDGE.
- The FSM, accumulator and counters stay in stage3_eval.

Test Plan:
- Nominal pass: pass2=1, bonus2=2, luck=1, hard=50, samples 60,70,80,90 → avg 75, total 87; at done: pass3=1, bonus3=2, score3=87, done 2 cycles after the 4th sample.
- Saturation and strict compare: four samples of 127, bonus2=3, luck=3, hard=100 → total 124 clamped to score3=100; pass3=0, bonus3=0.
- Pass2 bypass: start with pass2=0 → done on the next cycle with pass3=0, bonus3=0, score3=0; later work_vld pulses are ignored.
- Gapped samples and protocol violations: samples 20,0,0,40 separated by idle cycles, hard=5, bonus2=0, luck=0; extra start pulses while busy.
  - avg 15 → pass3=1, bonus3=0, score3=15.
  - The extra starts are ignored and only one done is produced.
- Reset mid-ACCUM: rst after 2 samples → all outputs 0, state IDLE, no done; a fresh evaluation then behaves as in the nominal case.
- STAGE3_TIMEOUT_EN build: 1 sample, then TIMEOUT_CYC=16 idle cycles → done with timeout=1 and pass3=0; a sample arriving on cycle 15 resets the idle counter and prevents the abort.
